prog_writer: RTL and testbench
==============================

Name: prog_writer

Overview:
- Generates the matrix-multiplier command program and writes it into program memory, one command per accepted write.
- The controller later fetches these commands sequentially from the same memory, and the command decoder turns them into write enables and select signals.
- Given a tile grid of rows x cols 2x2 block products, it emits per tile: eight operand loads, four result stores, then an advance command. It terminates the program with HALT.

Parameters:
CMD_WIDTH, 5, width of one command word
ADDR_WIDTH, 8, program memory address width (depth 2^ADDR_WIDTH)
DIM_WIDTH, 4, width of tile-grid dimension inputs
BASE_ADDR, 0, first program memory address written

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to build a program; sampled only in IDLE
rows  input  DIM_WIDTH  tile rows; captured on accepted start
cols  input  DIM_WIDTH  tile columns; captured on accepted start
mem_ready  input  1  memory accepts the write this cycle
mem_we  output  1  write request
mem_addr  output  ADDR_WIDTH  write address
mem_data  output  CMD_WIDTH  command word
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when the HALT write is accepted
overflow  output  1  sticky; set when the program was truncated, cleared on next accepted start
prog_len  output  ADDR_WIDTH+1  count of accepted writes in the last program, valid when done

Behaviour:
- Opcodes:
  - NOP=0
  - LOAD_A..LOAD_H=1..8
  - STORE_J..STORE_M=9..12 (jklm_select 0..3)
  - COLUMN=13
  - NEXT_ROW=14
  - HALT=31
  - All other values are unused and never emitted.
- Reset (async, reset_n low): state IDLE; mem_we=0, mem_addr=BASE_ADDR, mem_data=0, busy=0, done=0, overflow=0, prog_len=0, tile counters 0.
- States:
  - IDLE, LOAD, STORE, ADV, HALT_WR, DONE.
  - IDLE: on start, capture rows/cols and set mem_addr=BASE_ADDR. Clear overflow and prog_len. If rows==0 or cols==0, go to HALT_WR; otherwise go to LOAD with op index 0.
  - LOAD: mem_data=1+idx. After the 8th accepted write, go to STORE with idx 0.
  - STORE: mem_data=9+idx. After the 4th accepted write, the next state depends on position:
    - Last tile (r==rows-1, c==cols-1): go to HALT_WR.
    - Otherwise: go to ADV.
  - ADV: if c<cols-1, write COLUMN and set c=c+1. Otherwise write NEXT_ROW and set c=0, r=r+1. Then go to LOAD.
  - HALT_WR: write HALT, then go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
- Handshake:
  - mem_we is high in LOAD/STORE/ADV/HALT_WR and low in IDLE and DONE.
  - A write is accepted on a rising edge with mem_we&&mem_ready.
  - mem_addr, mem_data, and the state hold stable until acceptance.
  - On acceptance: mem_addr increments and prog_len increments.
  - No combinational path from mem_ready to mem_we.
- Program length: 13*rows*cols accepted writes total (the last tile's advance slot is replaced by HALT). For rows=cols=0 the length is 1.
- Overflow:
  - If a non-HALT command is pending at address 2^ADDR_WIDTH-1, emit HALT there instead, set overflow=1, go to HALT_WR completion (DONE).
  - mem_addr never wraps past the top.
- start while busy is ignored. rows/cols changes while busy are ignored.
- reset_n asserted mid-program: immediate return to reset values. A partially written program is left in memory; no HALT is written.
- Latency:
  - First write request (mem_we=1) appears the cycle after start.
  - With mem_ready held high, done pulses 13*rows*cols+1 cycles after start.

Test Plan:
- rows=1, cols=1, mem_ready=1: writes 1,2,3,4,5,6,7,8,9,10,11,12,31 at addresses 0..12 → done on cycle 14 after start, prog_len=13, overflow=0.
- rows=2, cols=2, mem_ready=1: COLUMN at addrs 12 and 38, NEXT_ROW at addr 25, HALT at addr 51 → prog_len=52.
- rows=1, cols=1, mem_ready toggled 1010...: mem_addr/mem_data hold while ready=0, no duplicate or skipped writes → same 13-word image as the first case.
- rows=0, cols=3: single HALT at addr 0 → done the cycle after the write, prog_len=1.
- ADDR_WIDTH=4, rows=2, cols=1: HALT at addr 15 → overflow=1, prog_len=16. The next start with rows=1, cols=1 clears overflow.
- reset_n pulsed low at the write to addr 5 → outputs at reset values immediately, no further writes. A new start rewrites from addr 0.

Source files
------------

// File: rtl/prog_writer.sv
// prog_writer
//   Builds the matrix-multiplier command program and writes it into program
//   memory, one command per accepted write. For a rows x cols grid of 2x2
//   block products each tile gets eight operand loads (LOAD_A..LOAD_H), four
//   result stores (STORE_J..STORE_M) and one advance command (COLUMN or
//   NEXT_ROW). The last tile's advance slot is replaced by HALT.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      one-cycle build request, sampled only in IDLE
//   rows/cols  tile grid size, captured on an accepted start
//   mem_ready  memory accepts the current write this cycle
//   mem_we     write request
//   mem_addr   write address
//   mem_data   command word
//   busy       program generation in progress
//   done       one-cycle pulse after the HALT write is accepted
//   overflow   sticky: program truncated at the top of memory
//   prog_len   accepted writes in the last program
//   state_dbg  current FSM state encoding
//
// Handshake: a write is accepted on a rising clk edge where mem_we && mem_ready.
// mem_addr, mem_data and the FSM state hold until that edge. mem_we depends
// only on registered state, never on mem_ready.
module prog_writer #(
    parameter int CMD_WIDTH  = 5,
    parameter int ADDR_WIDTH = 8,
    parameter int DIM_WIDTH  = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DIM_WIDTH-1:0]  rows,
    input  logic [DIM_WIDTH-1:0]  cols,
    input  logic                  mem_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [CMD_WIDTH-1:0]  mem_data,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   prog_len,
    output logic [2:0]            state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_STORE   = 3'd2,
        S_ADV     = 3'd3,
        S_HALT_WR = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [CMD_WIDTH-1:0]  OP_LOAD0    = CMD_WIDTH'(1);
    localparam logic [CMD_WIDTH-1:0]  OP_STORE0   = CMD_WIDTH'(9);
    localparam logic [CMD_WIDTH-1:0]  OP_COLUMN   = CMD_WIDTH'(13);
    localparam logic [CMD_WIDTH-1:0]  OP_NEXT_ROW = CMD_WIDTH'(14);
    localparam logic [CMD_WIDTH-1:0]  OP_HALT     = CMD_WIDTH'(31);
    localparam logic [ADDR_WIDTH-1:0] TOP_ADDR    = '1;
    localparam logic [ADDR_WIDTH-1:0] BASE        = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE     = (ADDR_WIDTH+1)'(1);
    localparam logic [DIM_WIDTH-1:0]  DIM_ONE     = DIM_WIDTH'(1);

    state_t               state, state_n;
    logic [2:0]           idx;
    logic [DIM_WIDTH-1:0] r, c, rows_q, cols_q;
    logic                 accept, at_top, truncate, last_col, last_row;

    assign accept    = mem_we && mem_ready;
    assign at_top    = (mem_addr == TOP_ADDR);
    // Any non-HALT command landing on the last address is turned into HALT.
    assign truncate  = mem_we && at_top && (state != S_HALT_WR);
    assign last_col  = (c == cols_q - DIM_ONE);
    assign last_row  = (r == rows_q - DIM_ONE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n  = state;
        mem_we   = 1'b0;
        mem_data = '0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (rows == '0 || cols == '0) state_n = S_HALT_WR;
                    else                          state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                mem_we   = 1'b1;
                busy     = 1'b1;
                mem_data = OP_LOAD0 + CMD_WIDTH'(idx);
                if (accept && idx == 3'd7) state_n = S_STORE;
            end
            S_STORE: begin
                mem_we   = 1'b1;
                busy     = 1'b1;
                mem_data = OP_STORE0 + CMD_WIDTH'(idx);
                if (accept && idx == 3'd3) begin
                    if (last_row && last_col) state_n = S_HALT_WR;
                    else                      state_n = S_ADV;
                end
            end
            S_ADV: begin
                mem_we   = 1'b1;
                busy     = 1'b1;
                mem_data = last_col ? OP_NEXT_ROW : OP_COLUMN;
                if (accept) state_n = S_LOAD;
            end
            S_HALT_WR: begin
                mem_we   = 1'b1;
                busy     = 1'b1;
                mem_data = OP_HALT;
                if (accept) state_n = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (truncate) begin
            mem_data = OP_HALT;
            if (accept) state_n = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_addr <= BASE;
            prog_len <= '0;
            overflow <= 1'b0;
            idx      <= '0;
            r        <= '0;
            c        <= '0;
            rows_q   <= '0;
            cols_q   <= '0;
        end else if (state == S_IDLE && start) begin
            rows_q   <= rows;
            cols_q   <= cols;
            mem_addr <= BASE;
            prog_len <= '0;
            overflow <= 1'b0;
            idx      <= '0;
            r        <= '0;
            c        <= '0;
        end else if (accept) begin
            prog_len <= prog_len + LEN_ONE;
            // Saturate at the top address; the program ends there anyway.
            if (!at_top) mem_addr <= mem_addr + ADDR_WIDTH'(1);
            if (truncate) overflow <= 1'b1;
            case (state)
                S_LOAD:  idx <= idx + 3'd1;
                S_STORE: idx <= (idx == 3'd3) ? 3'd0 : idx + 3'd1;
                S_ADV: begin
                    if (last_col) begin
                        c <= '0;
                        r <= r + DIM_ONE;
                    end else begin
                        c <= c + DIM_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_writer.sv
// Directed bench for prog_writer. A default instance (ADDR_WIDTH=8) covers
// program images, handshake stalls, empty grids and mid-program reset; a
// small instance (ADDR_WIDTH=4) covers truncation at the top of memory.
module tb_prog_writer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, mem_ready;
    logic [3:0] rows, cols;
    logic       mem_we, busy, done, overflow;
    logic [7:0] mem_addr;
    logic [4:0] mem_data;
    logic [8:0] prog_len;
    logic [2:0] state_dbg;

    logic       start2, ready2;
    logic [3:0] rows2, cols2;
    logic       we2, busy2, done2, ovf2;
    logic [3:0] addr2;
    logic [4:0] data2;
    logic [4:0] plen2;
    logic [2:0] state2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    // Write log of the default instance (order of accepted writes).
    logic [4:0] wr_data [64];
    logic [7:0] wr_addr [64];
    int         wr_cnt = 0;
    // Memory image of the small instance, indexed by address.
    logic [4:0] mem2 [16];
    int         cnt2 = 0;

    logic [4:0] exp1 [13] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                              5'd9, 5'd10, 5'd11, 5'd12, 5'd31};

    logic [7:0] snap_a;
    logic [4:0] snap_d;
    logic       was_ready;

    always #5 clk = ~clk;

    prog_writer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .rows(rows), .cols(cols),
        .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_data(mem_data), .busy(busy), .done(done), .overflow(overflow),
        .prog_len(prog_len), .state_dbg(state_dbg)
    );

    prog_writer #(.ADDR_WIDTH(4)) dut_small (
        .clk(clk), .reset_n(reset_n), .start(start2), .rows(rows2), .cols(cols2),
        .mem_ready(ready2), .mem_we(we2), .mem_addr(addr2),
        .mem_data(data2), .busy(busy2), .done(done2), .overflow(ovf2),
        .prog_len(plen2), .state_dbg(state2)
    );

    always @(posedge clk) begin
        if (reset_n && mem_we && mem_ready && wr_cnt < 64) begin
            wr_data[wr_cnt] = mem_data;
            wr_addr[wr_cnt] = mem_addr;
            wr_cnt++;
        end
        if (reset_n && we2 && ready2) begin
            mem2[addr2] = data2;
            cnt2++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // Start is high for the edge that ends cycle 0; returns at cycle 1.
    // rows/cols are scrambled afterwards to show they were captured.
    task automatic run_start(input logic [3:0] r, input logic [3:0] c);
        wr_cnt = 0;
        rows   = r;
        cols   = c;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        rows   = 4'($urandom_range(0, 15));
        cols   = 4'($urandom_range(0, 15));
        cyc    = 1;
    endtask

    task automatic wait_done(input int budget);
        while (!done && cyc < budget) step();
        chk("done_seen", done, 1);
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0; rows = '0; cols = '0; mem_ready = 1'b0;
        start2 = 1'b0; rows2 = '0; cols2 = '0; ready2 = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", mem_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_len", prog_len, 0);
        chk("rst_state", state_dbg, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1x1 grid, memory always ready
        mem_ready = 1'b1;
        run_start(4'd1, 4'd1);
        chk("t1_we_first", mem_we, 1);
        chk("t1_busy", busy, 1);
        chk("t1_addr0", mem_addr, 0);
        chk("t1_data0", mem_data, 1);
        wait_done(40);
        chk("t1_latency", cyc, 14);
        chk("t1_len", prog_len, 13);
        chk("t1_ovf", overflow, 0);
        chk("t1_busy_done", busy, 0);
        chk("t1_wr_cnt", wr_cnt, 13);
        for (int i = 0; i < 13; i++) begin
            chk("t1_img_data", wr_data[i], exp1[i]);
            chk("t1_img_addr", wr_addr[i], i);
        end
        step();
        chk("t1_done_pulse", done, 0);

        // 2x2 grid; a start pulse mid-program must be ignored
        run_start(4'd2, 4'd2);
        repeat (3) step();
        start = 1'b1; rows = 4'd1; cols = 4'd1;
        step();
        start = 1'b0;
        wait_done(80);
        chk("t2_latency", cyc, 53);
        chk("t2_len", prog_len, 52);
        chk("t2_wr_cnt", wr_cnt, 52);
        chk("t2_col_a", wr_data[12], 13);
        chk("t2_row", wr_data[25], 14);
        chk("t2_col_b", wr_data[38], 13);
        chk("t2_halt", wr_data[51], 31);
        chk("t2_halt_addr", wr_addr[51], 51);
        chk("t2_tile2_load", wr_data[26], 1);
        chk("t2_tile1_store", wr_data[24], 12);
        step();

        // 1x1 grid with mem_ready toggling 1,0,1,0...
        mem_ready = 1'b1;
        run_start(4'd1, 4'd1);
        while (!done && cyc < 80) begin
            snap_a    = mem_addr;
            snap_d    = mem_data;
            was_ready = mem_ready;
            step();
            if (!was_ready) begin
                chk("t3_hold_addr", mem_addr, snap_a);
                chk("t3_hold_data", mem_data, snap_d);
            end
            mem_ready = ~mem_ready;
        end
        chk("t3_done", done, 1);
        chk("t3_len", prog_len, 13);
        chk("t3_wr_cnt", wr_cnt, 13);
        for (int i = 0; i < 13; i++) begin
            chk("t3_img_data", wr_data[i], exp1[i]);
            chk("t3_img_addr", wr_addr[i], i);
        end
        mem_ready = 1'b1;
        step();

        // Empty grid: a single HALT
        run_start(4'd0, 4'd3);
        chk("t4_data", mem_data, 31);
        chk("t4_addr", mem_addr, 0);
        wait_done(10);
        chk("t4_latency", cyc, 2);
        chk("t4_len", prog_len, 1);
        chk("t4_wr_cnt", wr_cnt, 1);
        chk("t4_halt", wr_data[0], 31);
        step();

        // Small memory: 2x1 needs 26 words, truncated at address 15
        ready2 = 1'b1;
        cnt2 = 0;
        rows2 = 4'd2; cols2 = 4'd1; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 1;
        while (!done2 && cyc < 60) step();
        chk("t5_done", done2, 1);
        chk("t5_ovf", ovf2, 1);
        chk("t5_len", plen2, 16);
        chk("t5_cnt", cnt2, 16);
        chk("t5_halt15", mem2[15], 31);
        chk("t5_load14", mem2[14], 2);
        chk("t5_row12", mem2[12], 14);
        chk("t5_addr_top", addr2, 15);
        step();
        chk("t5_ovf_sticky", ovf2, 1);
        rows2 = 4'd1; cols2 = 4'd1; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        cyc = 1;
        chk("t5_ovf_clear", ovf2, 0);
        while (!done2 && cyc < 60) step();
        chk("t5b_done", done2, 1);
        chk("t5b_ovf", ovf2, 0);
        chk("t5b_len", plen2, 13);
        chk("t5b_halt12", mem2[12], 31);
        step();

        // Reset while the write to address 5 is pending
        mem_ready = 1'b1;
        run_start(4'd1, 4'd1);
        while (mem_addr != 8'd5 && cyc < 20) step();
        chk("t6_reach5", mem_addr, 5);
        reset_n = 1'b0;
        #1;
        chk("t6_we", mem_we, 0);
        chk("t6_addr", mem_addr, 0);
        chk("t6_data", mem_data, 0);
        chk("t6_busy", busy, 0);
        chk("t6_len", prog_len, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) step();
        chk("t6_wr_cnt", wr_cnt, 5);
        chk("t6_idle_we", mem_we, 0);
        run_start(4'd1, 4'd1);
        wait_done(40);
        chk("t6b_len", prog_len, 13);
        chk("t6b_wr_cnt", wr_cnt, 13);
        chk("t6b_first_addr", wr_addr[0], 0);
        chk("t6b_first_data", wr_data[0], 1);
        chk("t6b_halt", wr_data[12], 31);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
